// File: rtl/mul_addshift_ms_pkg.sv
// Shared definitions for the add-shift multiplier: state encodings and
// parameter helpers (step count, counter width, STEP_W legality).
package mul_addshift_ms_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

    function automatic int n_steps(input int data_w, input int step_w);
        return data_w / step_w;
    endfunction

    // A single-step build still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit step_w_legal(input int data_w, input int step_w);
        return (data_w >= 2) &&
               (step_w == 1 || step_w == 2 || step_w == 4) &&
               (data_w % step_w == 0);
    endfunction

endpackage

// File: rtl/mul_pp_gen.sv
// Combinational partial-product generator: a_r times one STEP_W-bit chunk of
// the multiplier, with the chunk MSB weighted negatively on a signed last step.
module mul_pp_gen #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 1
) (
    input  logic [2*DATA_W-1:0] a_r,
    input  logic [STEP_W-1:0]   chunk,
    input  logic                neg_msb,
    output logic [2*DATA_W-1:0] pp
);

    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP_W; i++) begin
            if (chunk[i]) begin
                if (i == STEP_W - 1 && neg_msb) pp = pp - (a_r << i);
                else                            pp = pp + (a_r << i);
            end
        end
    end

endmodule

// File: rtl/mul_addshift_ms.sv
// Iterative add-shift multiplier retiring STEP_W multiplier bits per cycle.
// Define MUL_ADDSHIFT_MS_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_addshift_ms
    import mul_addshift_ms_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                ready,
    input  logic                sign_a,
    input  logic                sign_b,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                done,
    output logic [2*DATA_W-1:0] product
);

    localparam int N_STEPS = n_steps(DATA_W, STEP_W);
    localparam int CNT_W   = cnt_width(N_STEPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEPS - 1);

    if (!step_w_legal(DATA_W, STEP_W)) begin : g_bad_params
        $error("mul_addshift_ms: illegal DATA_W/STEP_W combination");
    end

    state_e              state_q, state_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                sb_q, sb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] product_q, product_d;
    logic                done_q, done_d;
    logic [2*DATA_W-1:0] pp;
    logic                neg_msb;

    // Only the final chunk of a signed multiplier carries negative weight.
    assign neg_msb = sb_q && (cnt_q == LAST);

    mul_pp_gen #(.DATA_W(DATA_W), .STEP_W(STEP_W)) u_pp_gen (
        .a_r     (a_q),
        .chunk   (b_q[STEP_W-1:0]),
        .neg_msb (neg_msb),
        .pp      (pp)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    a_d     = sign_a ? {{DATA_W{op_a[DATA_W-1]}}, op_a}
                                     : {{DATA_W{1'b0}}, op_a};
                    b_d     = op_b;
                    sb_d    = sign_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + (pp << (cnt_q * STEP_W));
                b_d   = b_q >> STEP_W;
                cnt_d = cnt_q + 1'b1;
`ifdef MUL_ADDSHIFT_MS_EARLY_EXIT_EN
                if (cnt_q == LAST || b_d == '0) state_d = ST_DONE;
`else
                if (cnt_q == LAST) state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sb_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sb_q      <= sb_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_mul_addshift_ms.sv
// Directed bench for mul_addshift_ms: four instances (4/1, 8/2, 8/4, 8/1)
// sharing clock, reset and operand buses, each with its own start strobe.
module tb_mul_addshift_ms;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en_v;
    logic        sa, sb;
    logic [7:0]  opa, opb;
    logic [3:0]  rdy_v, dn_v;
    logic [7:0]  p4;
    logic [15:0] p82, p84, p81;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_addshift_ms #(.DATA_W(4), .STEP_W(1)) u_m41 (
        .clk(clk), .rst(rst), .en(en_v[0]), .ready(rdy_v[0]), .sign_a(sa), .sign_b(sb),
        .op_a(opa[3:0]), .op_b(opb[3:0]), .done(dn_v[0]), .product(p4));
    mul_addshift_ms #(.DATA_W(8), .STEP_W(2)) u_m82 (
        .clk(clk), .rst(rst), .en(en_v[1]), .ready(rdy_v[1]), .sign_a(sa), .sign_b(sb),
        .op_a(opa), .op_b(opb), .done(dn_v[1]), .product(p82));
    mul_addshift_ms #(.DATA_W(8), .STEP_W(4)) u_m84 (
        .clk(clk), .rst(rst), .en(en_v[2]), .ready(rdy_v[2]), .sign_a(sa), .sign_b(sb),
        .op_a(opa), .op_b(opb), .done(dn_v[2]), .product(p84));
    mul_addshift_ms #(.DATA_W(8), .STEP_W(1)) u_m81 (
        .clk(clk), .rst(rst), .en(en_v[3]), .ready(rdy_v[3]), .sign_a(sa), .sign_b(sb),
        .op_a(opa), .op_b(opb), .done(dn_v[3]), .product(p81));

    function automatic logic [15:0] psel(input int s);
        case (s)
            0:       return {8'h00, p4};
            1:       return p82;
            2:       return p84;
            default: return p81;
        endcase
    endfunction

    // Issue one operation on instance sel and watch a fixed 20-edge window.
    task automatic run_op(input int sel, input logic a_s, input logic b_s,
                          input logic [7:0] a, input logic [7:0] b,
                          output int de, output int low, output int pulses,
                          output logic [15:0] prod);
        sa = a_s; sb = b_s; opa = a; opb = b;
        en_v[sel] = 1'b1;
        @(posedge clk); #1;
        en_v = '0;
        de = -1; low = 0; pulses = 0; prod = '0;
        for (int e = 1; e <= 20; e++) begin
            if (!rdy_v[sel]) low++;
            @(posedge clk); #1;
            if (dn_v[sel]) begin
                pulses++;
                if (de < 0) begin
                    de   = e;
                    prod = psel(sel);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en_v = '0; sa = 0; sb = 0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (rdy_v !== 4'hF) begin errors++; $display("FAIL reset_ready got=%b exp=1111", rdy_v); end
        checks++; if (dn_v !== 4'h0) begin errors++; $display("FAIL reset_done got=%b exp=0000", dn_v); end
        checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL reset_product got=%h exp=00", p4); end
    endtask

    task automatic test_unsigned();
        int de, low, pulses; logic [15:0] p;
        run_op(0, 0, 0, 8'h0F, 8'h0F, de, low, pulses, p);
        checks++; if (p !== 16'h00E1) begin errors++; $display("FAIL u15x15_product got=%h exp=00e1", p); end
        checks++; if (de !== 5) begin errors++; $display("FAIL u15x15_done_edge got=%0d exp=5", de); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL u15x15_pulses got=%0d exp=1", pulses); end
        checks++; if (low !== 5) begin errors++; $display("FAIL u15x15_ready_low got=%0d exp=5", low); end
    endtask

    task automatic test_signed();
        int de, low, pulses; logic [15:0] p;
        run_op(0, 1, 1, 8'h08, 8'h08, de, low, pulses, p);
        checks++; if (p !== 16'h0040) begin errors++; $display("FAIL s_m8xm8 got=%h exp=0040", p); end
        run_op(0, 1, 1, 8'h07, 8'h07, de, low, pulses, p);
        checks++; if (p !== 16'h0031) begin errors++; $display("FAIL s_7x7 got=%h exp=0031", p); end
        run_op(0, 1, 1, 8'h0E, 8'h03, de, low, pulses, p);
        checks++; if (p !== 16'h00FA) begin errors++; $display("FAIL s_m2x3 got=%h exp=00fa", p); end
    endtask

    task automatic test_mixed();
        int de, low, pulses; logic [15:0] p;
        run_op(0, 1, 0, 8'h0E, 8'h0F, de, low, pulses, p);
        checks++; if (p !== 16'h00E2) begin errors++; $display("FAIL su_m2x15 got=%h exp=00e2", p); end
        run_op(0, 0, 1, 8'h0E, 8'h0F, de, low, pulses, p);
        checks++; if (p !== 16'h00F2) begin errors++; $display("FAIL us_14xm1 got=%h exp=00f2", p); end
    endtask

    task automatic test_wide_steps();
        int de, low, pulses; logic [15:0] p;
        run_op(1, 1, 1, 8'h80, 8'h80, de, low, pulses, p);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL s2_80x80 got=%h exp=4000", p); end
        checks++; if (de !== 5) begin errors++; $display("FAIL s2_done_edge got=%0d exp=5", de); end
        run_op(2, 1, 1, 8'h80, 8'h80, de, low, pulses, p);
        checks++; if (p !== 16'h4000) begin errors++; $display("FAIL s4_80x80 got=%h exp=4000", p); end
        checks++; if (de !== 3) begin errors++; $display("FAIL s4_done_edge got=%0d exp=3", de); end
        run_op(1, 1, 1, 8'h7F, 8'hFF, de, low, pulses, p);
        checks++; if (p !== 16'hFF81) begin errors++; $display("FAIL s2_7fxff got=%h exp=ff81", p); end
        run_op(2, 1, 1, 8'h7F, 8'hFF, de, low, pulses, p);
        checks++; if (p !== 16'hFF81) begin errors++; $display("FAIL s4_7fxff got=%h exp=ff81", p); end
    endtask

    task automatic test_reset_mid_run();
        int de, low, pulses; logic [15:0] p;
        sa = 0; sb = 0; opa = 8'h0F; opb = 8'h0F;
        en_v[0] = 1'b1;
        @(posedge clk); #1;
        en_v = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (rdy_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", rdy_v[0]); end
        checks++; if (dn_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", dn_v[0]); end
        checks++; if (p4 !== 8'h00) begin errors++; $display("FAIL midrst_product got=%h exp=00", p4); end
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (dn_v[0]) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
        run_op(0, 1, 1, 8'h03, 8'h0F, de, low, pulses, p);
        checks++; if (p !== 16'h00FD) begin errors++; $display("FAIL midrst_3xm1 got=%h exp=00fd", p); end
        checks++; if (de !== 5) begin errors++; $display("FAIL midrst_done_edge got=%0d exp=5", de); end
    endtask

    task automatic test_back_to_back();
        int n; int edg[2]; logic [7:0] pr[2];
        n = 0; edg[0] = -1; edg[1] = -1; pr[0] = '0; pr[1] = '0;
        sa = 0; sb = 0; opa = 8'h03; opb = 8'h05;
        en_v[0] = 1'b1;
        @(posedge clk); #1;
        // Operands change mid-run; only the second acceptance may see them.
        opa = 8'h02; opb = 8'h07;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); #1;
            if (dn_v[0]) begin
                if (n < 2) begin edg[n] = e; pr[n] = p4; end
                n++;
            end
        end
        en_v = '0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", n); end
        checks++; if (edg[0] !== 5) begin errors++; $display("FAIL b2b_edge0 got=%0d exp=5", edg[0]); end
        checks++; if (edg[1] !== 11) begin errors++; $display("FAIL b2b_edge1 got=%0d exp=11", edg[1]); end
        checks++; if (pr[0] !== 8'h0F) begin errors++; $display("FAIL b2b_prod0 got=%h exp=0f", pr[0]); end
        checks++; if (pr[1] !== 8'h0E) begin errors++; $display("FAIL b2b_prod1 got=%h exp=0e", pr[1]); end
    endtask

`ifdef MUL_ADDSHIFT_MS_EARLY_EXIT_EN
    task automatic test_early_exit();
        int de, low, pulses; logic [15:0] p;
        run_op(3, 0, 0, 8'h05, 8'h01, de, low, pulses, p);
        checks++; if (p !== 16'h0005) begin errors++; $display("FAIL ee_5x1 got=%h exp=0005", p); end
        checks++; if (de !== 2) begin errors++; $display("FAIL ee_5x1_edge got=%0d exp=2", de); end
        run_op(3, 0, 0, 8'h05, 8'h00, de, low, pulses, p);
        checks++; if (p !== 16'h0000) begin errors++; $display("FAIL ee_5x0 got=%h exp=0000", p); end
        checks++; if (de !== 2) begin errors++; $display("FAIL ee_5x0_edge got=%0d exp=2", de); end
        run_op(3, 1, 1, 8'h05, 8'hFF, de, low, pulses, p);
        checks++; if (p !== 16'hFFFB) begin errors++; $display("FAIL ee_5xm1 got=%h exp=fffb", p); end
        checks++; if (de !== 9) begin errors++; $display("FAIL ee_5xm1_edge got=%0d exp=9", de); end
    endtask
`else
    task automatic test_fixed_latency();
        int de, low, pulses; logic [15:0] p;
        run_op(3, 0, 0, 8'h05, 8'h01, de, low, pulses, p);
        checks++; if (p !== 16'h0005) begin errors++; $display("FAIL fl_5x1 got=%h exp=0005", p); end
        checks++; if (de !== 9) begin errors++; $display("FAIL fl_5x1_edge got=%0d exp=9", de); end
        run_op(3, 1, 1, 8'h05, 8'hFF, de, low, pulses, p);
        checks++; if (p !== 16'hFFFB) begin errors++; $display("FAIL fl_5xm1 got=%h exp=fffb", p); end
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_mixed();
        test_wide_steps();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MUL_ADDSHIFT_MS_EARLY_EXIT_EN
        test_early_exit();
`else
        test_fixed_latency();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
